// File: rtl/fifo_sync_flags_pkg.sv
// Shared definitions for the fifo_sync_flags block: default geometry,
// depth helper and pointer/count types for the default configuration.
package fifo_pkg;

  // Default geometry, shared by the FIFO top, its interface and the bench.
  localparam int FIFO_ADDR_WIDTH = 5;
  localparam int FIFO_DATA_WIDTH = 8;

  // Number of words addressed by addr_width address bits.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Pointer with wrap bit: the extra MSB distinguishes full from empty
  // when the address bits of both pointers are equal.
  typedef logic [FIFO_ADDR_WIDTH:0] fifo_ptr_t;

  // Fill level, 0..DEPTH inclusive, hence one bit wider than an address.
  typedef logic [FIFO_ADDR_WIDTH:0] fifo_cnt_t;

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer-facing signal bundle of fifo_sync_flags.
//
// Handshake: Wr_enable and Read_enable are requests sampled at posedge clk.
// A write is accepted when the FIFO is not full, or when it is full and a
// read is accepted in the same cycle; a read is accepted when the FIFO is
// not empty. A rejected request does not stall or retry: it is dropped and
// the sticky overflow/underflow flag records it. The full/empty flags seen
// before the edge tell the requester whether a request will be accepted.
interface fifo_sync_flags_if #(
  parameter int ADDR_WIDTH = fifo_pkg::FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH
);

  // Requests and write data (from the producer/consumer side)
  logic                  Wr_enable;
  logic                  Read_enable;
  logic [DATA_WIDTH-1:0] data_in;

  // Read data, status and error flags (from the FIFO)
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  // Exported address pointers, for observation only
  logic [ADDR_WIDTH-1:0] write_ptr;
  logic [ADDR_WIDTH-1:0] read_ptr;

  // Side that issues requests and consumes status
  modport master (
    output Wr_enable, Read_enable, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count,
    input  overflow, underflow, write_ptr, read_ptr
  );

  // The FIFO itself
  modport slave (
    input  Wr_enable, Read_enable, data_in,
    output data_out, full, empty, almost_full, almost_empty, count,
    output overflow, underflow, write_ptr, read_ptr
  );

endinterface

// File: rtl/fifo_sync_flags_mem.sv
// fifo_mem: simple dual-port storage for fifo_sync_flags, one write port and
// one read port on the same clock.
// Build option FIFO_FWFT_EN: when defined the read port is combinational
// (first-word-fall-through); otherwise it is a registered port that loads
// only on an accepted read and clears to zero on reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  // Storage is deliberately not reset; only the pointers define validity.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the word when the top accepts a write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly from registered read address; the
  // pop itself is handled entirely by the read pointer in the top.
  assign rdata = mem[raddr];

  logic unused_rd_ctrl;
  assign unused_rd_ctrl = ^{re, reset};
`else
  logic [DATA_WIDTH-1:0] rdata_q;

  // Registered read port: load on accepted read, hold otherwise. When the
  // FIFO is full and both ports hit the same address, the old word is read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: parametrised single-clock FIFO with programmable
// almost-full/almost-empty thresholds, fill level and sticky error flags.
// Build option FIFO_FWFT_EN selects first-word-fall-through read data;
// flags, count and error behaviour are the same in both modes.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
  parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input logic              clk,
  input logic              reset,
  fifo_sync_flags_if.slave fif
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  localparam logic [PW-1:0] DEPTH_C   = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C   = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_C  = PW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  // Pointers carry a wrap bit above the address bits.
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          overflow_q;
  logic          underflow_q;

  // Status derived only from registered pointers.
  logic [PW-1:0] count_w;
  logic          empty_w;
  logic          full_w;

  // Acceptance decisions from pre-edge state.
  logic          rd_ok;
  logic          wr_ok;
  logic          wr_reject;
  logic          rd_reject;
  logic          mem_we;

  // Pointer difference modulo 2*DEPTH is exactly the fill level 0..DEPTH.
  assign count_w = wr_ptr_q - rd_ptr_q;
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (count_w == DEPTH_C);

  // A read is needed before a write can be taken at full, so the write
  // decision depends on the read decision and not the other way round.
  assign rd_ok     = fif.Read_enable && !empty_w;
  assign wr_ok     = fif.Wr_enable && (!full_w || rd_ok);
  assign wr_reject = fif.Wr_enable && !wr_ok;
  assign rd_reject = fif.Read_enable && !rd_ok;

  // Reset wins over a same-cycle write, so the storage is not touched then.
  assign mem_we = wr_ok && reset;

  // Pointer and sticky error state; errors clear only through reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (wr_reject) begin
        overflow_q <= 1'b1;
      end
      if (rd_reject) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Storage and read data path; read mode depends on FIFO_FWFT_EN.
  fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (fif.data_in),
    .re    (rd_ok),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (fif.data_out)
  );

  // Status outputs, all functions of registered state only.
  assign fif.count        = count_w;
  assign fif.empty        = empty_w;
  assign fif.full         = full_w;
  assign fif.almost_full  = (count_w >= AFULL_C);
  assign fif.almost_empty = (count_w <= AEMPTY_C);
  assign fif.overflow     = overflow_q;
  assign fif.underflow    = underflow_q;
  assign fif.write_ptr    = wr_ptr_q[ADDR_WIDTH-1:0];
  assign fif.read_ptr     = rd_ptr_q[ADDR_WIDTH-1:0];

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO. Next generation of the team's 32x8 FIFO: configurable width and depth, programmable almost-full/almost-empty thresholds, fill-level output and sticky overflow/underflow error flags. Sits between producer and consumer blocks in the same clock domain. Pointer outputs are exported so the bench interface can sample them.

Parameters:
- ADDR_WIDTH, 5, address bits; depth DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 8, word width in bits
- AFULL_THRESH, DEPTH-2, almost_full asserted when count >= AFULL_THRESH; legal range 1..DEPTH
- AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH; legal range 0..DEPTH-1

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-low reset
- Wr_enable  in  1  write request
- Read_enable  in  1  read request
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDR_WIDTH+1  current fill level, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected
- write_ptr  out  ADDR_WIDTH  next write address
- read_ptr  out  ADDR_WIDTH  next read address

Behaviour:
- Reset (reset==0 at posedge): write_ptr=0, read_ptr=0, count=0, data_out=0, overflow=0, underflow=0. Result: empty=1, full=0, almost_empty=1, almost_full=(AFULL_THRESH==0 ? 1 : 0), which is 0 for legal thresholds. Memory contents are not cleared. Reset overrides any same-cycle Wr_enable/Read_enable.
- Internal pointers are ADDR_WIDTH+1 bits with a wrap bit. Exported pointers are the low ADDR_WIDTH bits. Pointers wrap from DEPTH-1 to 0.
- Acceptance is decided from pre-edge state:
  - rd_ok = Read_enable && !empty
  - wr_ok = Wr_enable && (!full || rd_ok)
- wr_ok: mem[write_ptr] <= data_in; write_ptr increments.
- rd_ok: data_out <= mem[read_ptr]; read_ptr increments. Read latency is 1 cycle. data_out holds its value when no read is accepted.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither are accepted.
- Full with both requests: read and write both accepted, count stays DEPTH, no overflow.
- Empty with both requests: write accepted, read rejected, underflow set. The written word is not bypassed to data_out.
- Write rejected (Wr_enable && !wr_ok): overflow <= 1. Stored data and pointers are untouched.
- Read rejected (Read_enable && !rd_ok): underflow <= 1. data_out is unchanged.
- overflow and underflow are cleared only by reset.
- All flags and count are registered or derived combinationally from registered pointers. No combinational path from Wr_enable or Read_enable to any output.

Optional Feature:
- Macro: FIFO_FWFT_EN
- Defined (first-word-fall-through):
  - data_out = mem[read_ptr] combinationally from registered state, so the head word is visible while !empty.
  - rd_ok pops the word and advances read_ptr; the next head appears in the same cycle after the edge.
  - data_out is don't-care while empty.
  - Reset value of data_out is not applicable.
- Undefined: standard 1-cycle registered read, as described in Behaviour.
- Flag, count and error behaviour is identical in both modes.

Decomposition:
- Package fifo_pkg holds:
  - localparam helper function for DEPTH
  - typedef fifo_ptr_t (ADDR_WIDTH+1 bits)
  - typedef fifo_cnt_t
  - default ADDR_WIDTH and DATA_WIDTH constants shared with the bench interface
- One sub-module fifo_mem: simple dual-port RAM with 1 write port and 1 read port, parameters ADDR_WIDTH and DATA_WIDTH. Its read port is registered or combinational according to FIFO_FWFT_EN.
- Top level holds pointers, count, flags and error logic.

Test Plan:
- Reset mid-operation: write 5 words, then reset=0 for 1 cycle with Wr_enable=1 -> count=0, empty=1, pointers=0, overflow=0.
- Fill and drain at default parameters: 32 writes of 0x00..0x1F -> full=1 after the 32nd edge, almost_full=1 from count=30. Then 32 reads -> data_out 0x00..0x1F in order, each 1 cycle after its read; empty=1 at the end.
- Overflow: at full, write 0xAA with Read_enable=0 -> overflow=1, count=32, next 32 reads unaffected.
- Underflow: at empty, Read_enable=1 -> underflow=1, data_out unchanged, read_ptr=0.
- Simultaneous: at full, Wr_enable=Read_enable=1 with 0x55 -> count stays 32, no overflow, 0x55 read out 32 reads later. At empty with both asserted -> count=1, underflow=1.
- Wrap and thresholds: ADDR_WIDTH=3, AFULL_THRESH=6, AEMPTY_THRESH=1; 20 interleaved writes/reads -> pointers wrap 7->0, data order preserved, almost flags toggle exactly at count 6 and 1. Repeat with FIFO_FWFT_EN defined -> head word visible with 0-cycle latency.
